// File: rtl/serial_alu_core.sv
// serial_alu_core: digit-serial multi-word ALU, NSHIFT bits per advance, LSB first.
// Flags commit on the final digit; a start on that same cycle chains the next operation.
module serial_alu_core #(
   parameter int NSHIFT    = 2,
   parameter int WORD_BITS = 8,
   parameter int MAX_WORDS = 2,
   parameter int OP_BITS   = 4,
   localparam int DPW      = WORD_BITS / NSHIFT,
   localparam int NDIG     = MAX_WORDS * DPW,
   localparam int CNT_BITS = (NDIG > 1) ? $clog2(NDIG) : 1,
   localparam int WB       = $clog2(MAX_WORDS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [OP_BITS-1:0]  operation,
   input  logic [WB-1:0]       num_words,
   input  logic [WB-1:0]       arg2_words,
   input  logic                sext2,
   input  logic                advance,
   input  logic [NSHIFT-1:0]   arg1_in,
   input  logic [NSHIFT-1:0]   arg2_in,
   output logic [NSHIFT-1:0]   result_out,
   output logic                busy,
   output logic                op_done,
   output logic [CNT_BITS-1:0] digit_index,
   output logic                flag_c,
   output logic                flag_v,
   output logic                flag_s,
   output logic                flag_z
);
   localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(0);
   localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(1);
   localparam logic [OP_BITS-1:0] OP_ADC = OP_BITS'(2);
   localparam logic [OP_BITS-1:0] OP_SBC = OP_BITS'(3);
   localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(4);
   localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(5);
   localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(6);
   localparam logic [OP_BITS-1:0] OP_MOV = OP_BITS'(7);
   localparam logic [OP_BITS-1:0] OP_CMP = OP_BITS'(8);
   localparam logic [OP_BITS-1:0] OP_TST = OP_BITS'(9);
   localparam logic [OP_BITS-1:0] OP_NEG = OP_BITS'(10);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t r_state, w_next;
   logic [CNT_BITS-1:0] r_idx;
   logic [OP_BITS-1:0]  r_op;
   logic [WB-1:0]       r_nw, r_a2w, w_nw_eff;
   logic                r_carry, r_sign2, r_zacc, r_sext2;
   logic                r_flag_c, r_flag_v, r_flag_s, r_flag_z;
   logic                w_last, w_run_adv, w_latch, w_ext;
   logic                w_arith, w_sub, w_logic, w_cin, w_cmsb, w_v, w_zfin;
   logic [NSHIFT-1:0]   w_a1, w_a2, w_b, w_res, w_zd;
   logic [NSHIFT:0]     w_sum;

   assign w_nw_eff  = (num_words == '0 || int'(num_words) > MAX_WORDS) ? WB'(MAX_WORDS) : num_words;
   assign busy      = r_state == S_RUN;
   assign w_last    = int'(r_idx) == int'(r_nw) * DPW - 1;
   assign w_run_adv = busy & advance;
   assign op_done   = w_run_adv & w_last;
   assign w_latch   = start & ((r_state == S_IDLE) | op_done);

   // Digits past the valid arg2 length come from the running sign (or zero).
   assign w_ext   = r_a2w == '0 || int'(r_idx) >= int'(r_a2w) * DPW;
   assign w_a2    = w_ext ? {NSHIFT{r_sext2 & r_sign2}} : arg2_in;
   assign w_arith = r_op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP, OP_NEG};
   assign w_sub   = r_op inside {OP_SUB, OP_SBC, OP_CMP, OP_NEG};
   assign w_logic = r_op inside {OP_AND, OP_OR, OP_XOR, OP_TST};
   assign w_a1    = (r_op == OP_NEG) ? '0 : arg1_in;
   assign w_b     = w_sub ? ~w_a2 : w_a2;
   assign w_cin   = (r_idx != '0) ? r_carry : (r_op inside {OP_ADC, OP_SBC}) ? r_flag_c : w_sub;
   assign w_sum   = {1'b0, w_a1} + {1'b0, w_b} + {{NSHIFT{1'b0}}, w_cin};
   assign w_cmsb  = w_sum[NSHIFT-1] ^ w_a1[NSHIFT-1] ^ w_b[NSHIFT-1];
   assign w_v     = w_cmsb ^ w_sum[NSHIFT];

   assign w_res = !busy                          ? '0 :
                  (w_arith && r_op != OP_CMP)    ? w_sum[NSHIFT-1:0] :
                  (r_op == OP_AND)               ? arg1_in & w_a2 :
                  (r_op == OP_OR)                ? arg1_in | w_a2 :
                  (r_op == OP_XOR)               ? arg1_in ^ w_a2 :
                  (r_op == OP_MOV)               ? w_a2 : arg1_in;
   // Flag source: CMP flags follow the difference even though the data passes arg1 through.
   assign w_zd   = w_arith ? w_sum[NSHIFT-1:0] : (r_op == OP_TST) ? arg1_in & w_a2 : w_res;
   assign w_zfin = r_zacc & ~|w_zd;

   assign result_out  = w_res;
   assign digit_index = r_idx;
   assign flag_c      = r_flag_c;
   assign flag_v      = r_flag_v;
   assign flag_s      = r_flag_s;
   assign flag_z      = r_flag_z;

   always_comb begin
      w_next = r_state;
      if (w_latch) w_next = S_RUN;
      else if (op_done) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx    <= '0;
         r_op     <= '0;
         r_nw     <= '0;
         r_a2w    <= '0;
         r_sext2  <= 1'b0;
         r_carry  <= 1'b0;
         r_sign2  <= 1'b0;
         r_zacc   <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_v <= 1'b0;
         r_flag_s <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         if (w_latch) begin
            r_op    <= operation;
            r_nw    <= w_nw_eff;
            r_a2w   <= arg2_words;
            r_sext2 <= sext2;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sign2 <= 1'b0;
            r_zacc  <= 1'b1;
         end else if (w_run_adv) begin
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            r_carry <= w_sum[NSHIFT];
            r_sign2 <= w_a2[NSHIFT-1];
            r_zacc  <= w_zfin;
         end
         if (op_done && w_arith) begin
            r_flag_c <= w_sum[NSHIFT];
            r_flag_v <= w_v;
         end
         if (op_done && (w_arith || w_logic)) begin
            r_flag_s <= w_zd[NSHIFT-1];
            r_flag_z <= w_zfin;
         end
      end
   end
endmodule
